// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID/EX boundary bundle.
//   ID side   : OPCODE, FUNC3, control bundle, ALU_OP, PC/operands/immediate,
//               register indices, FLUSH, EX_HOLD.
//   EX side   : <INPUT>_OUT registered copies, combinational STALL and, when
//               ID_EX_BUBBLE_COUNT_EN is defined, BUBBLE_COUNT.
//   master    : drives the ID side (decode stage / testbench).
//   slave     : the id_ex_stage itself.
interface id_ex_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic [6:0]      OPCODE;
  logic [2:0]      FUNC3;
  logic            WRITE_EN;
  logic            MEM_WRITE;
  logic            MEM_READ;
  logic            BRANCH;
  logic            JUMP;
  logic            PC_SELECT;
  logic            IMM_SELECT;
  logic            JAL_SELECT;
  logic            DATA_MEM_SELECT;
  logic [2:0]      ALU_OP;
  logic [XLEN-1:0] PC_IN;
  logic [XLEN-1:0] DATA1_IN;
  logic [XLEN-1:0] DATA2_IN;
  logic [XLEN-1:0] IMM_IN;
  logic [4:0]      RS1_ADDR;
  logic [4:0]      RS2_ADDR;
  logic [4:0]      RD_ADDR;
  logic            FLUSH;
  logic            EX_HOLD;

  logic [2:0]      FUNC3_OUT;
  logic            WRITE_EN_OUT;
  logic            MEM_WRITE_OUT;
  logic            MEM_READ_OUT;
  logic            BRANCH_OUT;
  logic            JUMP_OUT;
  logic            PC_SELECT_OUT;
  logic            IMM_SELECT_OUT;
  logic            JAL_SELECT_OUT;
  logic            DATA_MEM_SELECT_OUT;
  logic [2:0]      ALU_OP_OUT;
  logic [XLEN-1:0] PC_IN_OUT;
  logic [XLEN-1:0] DATA1_IN_OUT;
  logic [XLEN-1:0] DATA2_IN_OUT;
  logic [XLEN-1:0] IMM_IN_OUT;
  logic [4:0]      RS1_ADDR_OUT;
  logic [4:0]      RS2_ADDR_OUT;
  logic [4:0]      RD_ADDR_OUT;
  logic            STALL;
`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [31:0]     BUBBLE_COUNT;
`endif

  modport master (
    output OPCODE, FUNC3, WRITE_EN, MEM_WRITE, MEM_READ, BRANCH, JUMP, PC_SELECT,
           IMM_SELECT, JAL_SELECT, DATA_MEM_SELECT, ALU_OP, PC_IN, DATA1_IN, DATA2_IN,
           IMM_IN, RS1_ADDR, RS2_ADDR, RD_ADDR, FLUSH, EX_HOLD,
    input
`ifdef ID_EX_BUBBLE_COUNT_EN
           BUBBLE_COUNT,
`endif
           FUNC3_OUT, WRITE_EN_OUT, MEM_WRITE_OUT, MEM_READ_OUT, BRANCH_OUT, JUMP_OUT,
           PC_SELECT_OUT, IMM_SELECT_OUT, JAL_SELECT_OUT, DATA_MEM_SELECT_OUT, ALU_OP_OUT,
           PC_IN_OUT, DATA1_IN_OUT, DATA2_IN_OUT, IMM_IN_OUT, RS1_ADDR_OUT, RS2_ADDR_OUT,
           RD_ADDR_OUT, STALL
  );

  modport slave (
    input  OPCODE, FUNC3, WRITE_EN, MEM_WRITE, MEM_READ, BRANCH, JUMP, PC_SELECT,
           IMM_SELECT, JAL_SELECT, DATA_MEM_SELECT, ALU_OP, PC_IN, DATA1_IN, DATA2_IN,
           IMM_IN, RS1_ADDR, RS2_ADDR, RD_ADDR, FLUSH, EX_HOLD,
    output
`ifdef ID_EX_BUBBLE_COUNT_EN
           BUBBLE_COUNT,
`endif
           FUNC3_OUT, WRITE_EN_OUT, MEM_WRITE_OUT, MEM_READ_OUT, BRANCH_OUT, JUMP_OUT,
           PC_SELECT_OUT, IMM_SELECT_OUT, JAL_SELECT_OUT, DATA_MEM_SELECT_OUT, ALU_OP_OUT,
           PC_IN_OUT, DATA1_IN_OUT, DATA2_IN_OUT, IMM_IN_OUT, RS1_ADDR_OUT, RS2_ADDR_OUT,
           RD_ADDR_OUT, STALL
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the RV32IM pipeline with load-use
// hazard detection. Inserts a one-cycle bubble and raises STALL when the ID
// instruction reads the destination of a load sitting in EX. FLUSH loads a
// bubble (highest priority after RESET), EX_HOLD freezes the stage.
// Ports:
//   CLK   : rising-edge clock
//   RESET : asynchronous, active-high reset; clears every output
//   bus   : id_ex_stage_if.slave carrying ID inputs, *_OUT registers, STALL
// Optional feature: define ID_EX_BUBBLE_COUNT_EN to build the 32-bit
// BUBBLE_COUNT port (load-use bubbles since reset, wrapping).
module id_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input logic          CLK,
  input logic          RESET,
  id_ex_stage_if.slave bus
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef struct packed {
    logic [2:0]      func3;
    logic            write_en;
    logic            mem_write;
    logic            mem_read;
    logic            branch;
    logic            jump;
    logic            pc_select;
    logic            imm_select;
    logic            jal_select;
    logic            data_mem_select;
    logic [2:0]      alu_op;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } stage_t;

  stage_t stage_q, stage_d, id_in;

  logic rs1_used;
  logic rs2_used;
  logic load_use;

  // Source-register usage from the ID opcode; unused fields hold immediate
  // bits and must not create false hazards.
  always_comb begin
    rs1_used = !((bus.OPCODE == OpLui) || (bus.OPCODE == OpAuipc) || (bus.OPCODE == OpJal));
    rs2_used = (bus.OPCODE == OpRType) || (bus.OPCODE == OpStore) || (bus.OPCODE == OpBranch);
  end

  // A load to x0 never produces a value worth waiting for.
  assign load_use = stage_q.mem_read && (stage_q.rd != 5'd0) &&
                    ((rs1_used && (bus.RS1_ADDR == stage_q.rd)) ||
                     (rs2_used && (bus.RS2_ADDR == stage_q.rd)));

  assign bus.STALL = (load_use && !bus.FLUSH) || bus.EX_HOLD;

  always_comb begin
    id_in.func3           = bus.FUNC3;
    id_in.write_en        = bus.WRITE_EN;
    id_in.mem_write       = bus.MEM_WRITE;
    id_in.mem_read        = bus.MEM_READ;
    id_in.branch          = bus.BRANCH;
    id_in.jump            = bus.JUMP;
    id_in.pc_select       = bus.PC_SELECT;
    id_in.imm_select      = bus.IMM_SELECT;
    id_in.jal_select      = bus.JAL_SELECT;
    id_in.data_mem_select = bus.DATA_MEM_SELECT;
    id_in.alu_op          = bus.ALU_OP;
    id_in.pc              = bus.PC_IN;
    id_in.data1           = bus.DATA1_IN;
    id_in.data2           = bus.DATA2_IN;
    id_in.imm             = bus.IMM_IN;
    id_in.rs1             = bus.RS1_ADDR;
    id_in.rs2             = bus.RS2_ADDR;
    id_in.rd              = bus.RD_ADDR;
  end

  // Priority: FLUSH > EX_HOLD > load-use bubble > capture.
  always_comb begin
    stage_d = stage_q;
    if (bus.FLUSH) begin
      stage_d = '0;
    end else if (bus.EX_HOLD) begin
      stage_d = stage_q;
    end else if (load_use) begin
      stage_d = '0;
    end else begin
      stage_d = id_in;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign bus.FUNC3_OUT           = stage_q.func3;
  assign bus.WRITE_EN_OUT        = stage_q.write_en;
  assign bus.MEM_WRITE_OUT       = stage_q.mem_write;
  assign bus.MEM_READ_OUT        = stage_q.mem_read;
  assign bus.BRANCH_OUT          = stage_q.branch;
  assign bus.JUMP_OUT            = stage_q.jump;
  assign bus.PC_SELECT_OUT       = stage_q.pc_select;
  assign bus.IMM_SELECT_OUT      = stage_q.imm_select;
  assign bus.JAL_SELECT_OUT      = stage_q.jal_select;
  assign bus.DATA_MEM_SELECT_OUT = stage_q.data_mem_select;
  assign bus.ALU_OP_OUT          = stage_q.alu_op;
  assign bus.PC_IN_OUT           = stage_q.pc;
  assign bus.DATA1_IN_OUT        = stage_q.data1;
  assign bus.DATA2_IN_OUT        = stage_q.data2;
  assign bus.IMM_IN_OUT          = stage_q.imm;
  assign bus.RS1_ADDR_OUT        = stage_q.rs1;
  assign bus.RS2_ADDR_OUT        = stage_q.rs2;
  assign bus.RD_ADDR_OUT         = stage_q.rd;

`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [31:0] bubble_count_q;

  // Counts load-use bubbles only; flushes and held cycles do not count.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bubble_count_q <= 32'd0;
    end else if (!bus.FLUSH && !bus.EX_HOLD && load_use) begin
      bubble_count_q <= bubble_count_q + 32'd1;
    end
  end

  assign bus.BUBBLE_COUNT = bubble_count_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  logic CLK;
  logic RESET;
  int   checks;
  int   failures;

  id_ex_stage_if #(.XLEN(32)) bus ();

  id_ex_stage #(.XLEN(32)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  logic [14:0]  ctrl_out;
  logic [157:0] all_out;
  assign ctrl_out = {bus.WRITE_EN_OUT, bus.MEM_WRITE_OUT, bus.MEM_READ_OUT, bus.BRANCH_OUT,
                     bus.JUMP_OUT, bus.PC_SELECT_OUT, bus.IMM_SELECT_OUT, bus.JAL_SELECT_OUT,
                     bus.DATA_MEM_SELECT_OUT, bus.ALU_OP_OUT, bus.FUNC3_OUT};
  assign all_out  = {ctrl_out, bus.PC_IN_OUT, bus.DATA1_IN_OUT, bus.DATA2_IN_OUT,
                     bus.IMM_IN_OUT, bus.RS1_ADDR_OUT, bus.RS2_ADDR_OUT, bus.RD_ADDR_OUT};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; leave time 1 unit after it for sampling/driving.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] alu, input logic we,
                           input logic mr, input logic mw, input logic imms,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                           input logic [31:0] pc);
    bus.OPCODE          = op;
    bus.FUNC3           = 3'b010;
    bus.ALU_OP          = alu;
    bus.WRITE_EN        = we;
    bus.MEM_READ        = mr;
    bus.MEM_WRITE       = mw;
    bus.IMM_SELECT      = imms;
    bus.DATA_MEM_SELECT = mr;
    bus.BRANCH          = (op == 7'b1100011);
    bus.JUMP            = (op == 7'b1101111);
    bus.JAL_SELECT      = (op == 7'b1101111);
    bus.PC_SELECT       = 1'b0;
    bus.PC_IN           = pc;
    bus.DATA1_IN        = pc ^ 32'hA5A5_0000;
    bus.DATA2_IN        = pc ^ 32'h5A5A_0000;
    bus.IMM_IN          = {27'd0, r2};
    bus.RS1_ADDR        = r1;
    bus.RS2_ADDR        = r2;
    bus.RD_ADDR         = rd;
  endtask

  task automatic set_random();
    bus.OPCODE          = 7'($urandom);
    bus.FUNC3           = 3'($urandom);
    bus.ALU_OP          = 3'($urandom);
    {bus.WRITE_EN, bus.MEM_WRITE, bus.MEM_READ, bus.BRANCH, bus.JUMP, bus.PC_SELECT,
     bus.IMM_SELECT, bus.JAL_SELECT, bus.DATA_MEM_SELECT} = 9'($urandom) | 9'h1;
    bus.PC_IN           = $urandom | 32'h1;
    bus.DATA1_IN        = $urandom;
    bus.DATA2_IN        = $urandom;
    bus.IMM_IN          = $urandom;
    bus.RS1_ADDR        = 5'($urandom);
    bus.RS2_ADDR        = 5'($urandom);
    bus.RD_ADDR         = 5'($urandom);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    RESET       = 1'b1;
    bus.FLUSH   = 1'b0;
    bus.EX_HOLD = 1'b0;
    set_instr(7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    step();
    step();
    RESET = 1'b0;

    // Reset asserted mid-cycle with random inputs
    set_random();
    step();
    set_random();
    step();
    #2;
    RESET = 1'b1;
    #1;
    check("rst_outputs_zero", 64'(|all_out), 64'd0);
    check("rst_stall", 64'(bus.STALL), 64'd0);
`ifdef ID_EX_BUBBLE_COUNT_EN
    check("rst_count", 64'(bus.BUBBLE_COUNT), 64'd0);
`endif
    step();
    RESET = 1'b0;

    // Pass-through: ADDI x5,x1,3
    set_instr(7'b0010011, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd3, 5'd5, 32'h100);
    #1;
    check("addi_stall", 64'(bus.STALL), 64'd0);
    step();
    check("addi_rd", 64'(bus.RD_ADDR_OUT), 64'd5);
    check("addi_aluop", 64'(bus.ALU_OP_OUT), 64'd3);
    check("addi_ctrl", 64'(ctrl_out), 64'(15'b100000100_011_010));
    check("addi_pc", 64'(bus.PC_IN_OUT), 64'h100);
    check("addi_imm", 64'(bus.IMM_IN_OUT), 64'd3);
    check("addi_data1", 64'(bus.DATA1_IN_OUT), 64'hA5A5_0100);
    check("addi_data2", 64'(bus.DATA2_IN_OUT), 64'h5A5A_0100);
    check("addi_rs", 64'({bus.RS1_ADDR_OUT, bus.RS2_ADDR_OUT}), 64'({5'd1, 5'd3}));

    // Load-use: LW x6 then ADD x7,x1,x6
    set_instr(7'b0000011, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 5'd6, 32'h104);
    step();
    check("lw_memread", 64'(bus.MEM_READ_OUT), 64'd1);
    set_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd6, 5'd7, 32'h108);
    #1;
    check("lu_stall", 64'(bus.STALL), 64'd1);
    step();
    check("lu_bubble_ctrl", 64'(ctrl_out), 64'd0);
    check("lu_bubble_rd", 64'(bus.RD_ADDR_OUT), 64'd0);
`ifdef ID_EX_BUBBLE_COUNT_EN
    check("lu_count", 64'(bus.BUBBLE_COUNT), 64'd1);
`endif
    check("lu_stall_clears", 64'(bus.STALL), 64'd0);
    step();
    check("lu_issue_rd", 64'(bus.RD_ADDR_OUT), 64'd7);
    check("lu_issue_pc", 64'(bus.PC_IN_OUT), 64'h108);

    // No false hazards
    set_instr(7'b0000011, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 5'd0, 32'h10C);
    step();
    set_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 32'h110);
    #1;
    check("x0_load_stall", 64'(bus.STALL), 64'd0);
    set_instr(7'b0000011, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 5'd6, 32'h114);
    step();
    set_instr(7'b0110111, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 5'd6, 5'd6, 32'h118);
    #1;
    check("lui_stall", 64'(bus.STALL), 64'd0);
    set_instr(7'b0010111, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 5'd6, 5'd9, 32'h118);
    #1;
    check("auipc_stall", 64'(bus.STALL), 64'd0);
    set_instr(7'b1101111, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 5'd6, 5'd1, 32'h118);
    #1;
    check("jal_stall", 64'(bus.STALL), 64'd0);
    set_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd6, 5'd9, 32'h118);
    #1;
    check("itype_rs2_stall", 64'(bus.STALL), 64'd0);
    set_instr(7'b0100011, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 5'd6, 5'd0, 32'h118);
    #1;
    check("store_rs2_stall", 64'(bus.STALL), 64'd1);
    set_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 5'd1, 5'd0, 32'h118);
    #1;
    check("branch_rs1_stall", 64'(bus.STALL), 64'd1);

    // FLUSH with EX_HOLD and load-use all at once
    set_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 5'd1, 5'd7, 32'h118);
    bus.FLUSH   = 1'b1;
    bus.EX_HOLD = 1'b1;
    #1;
    check("flush_hold_stall", 64'(bus.STALL), 64'd1);
    step();
    check("flush_ctrl", 64'(ctrl_out), 64'd0);
    check("flush_rd", 64'(bus.RD_ADDR_OUT), 64'd0);
`ifdef ID_EX_BUBBLE_COUNT_EN
    check("flush_count", 64'(bus.BUBBLE_COUNT), 64'd1);
`endif
    bus.FLUSH   = 1'b0;
    bus.EX_HOLD = 1'b0;
    set_instr(7'b0000011, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 5'd6, 32'h120);
    step();
    set_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 5'd1, 5'd7, 32'h124);
    bus.FLUSH = 1'b1;
    #1;
    check("flush_only_stall", 64'(bus.STALL), 64'd0);
    step();
    bus.FLUSH = 1'b0;
    check("flush_only_ctrl", 64'(ctrl_out), 64'd0);
`ifdef ID_EX_BUBBLE_COUNT_EN
    check("flush_only_count", 64'(bus.BUBBLE_COUNT), 64'd1);
`endif

    // Hold for three cycles while ID changes
    set_instr(7'b0010011, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd4, 5'd10, 32'h200);
    step();
    bus.EX_HOLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(7'b0010011, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd4, 5'(11 + i),
                32'h300 + 32'(4 * i));
      #1;
      check("hold_stall", 64'(bus.STALL), 64'd1);
      step();
      check("hold_pc", 64'(bus.PC_IN_OUT), 64'h200);
      check("hold_rd", 64'(bus.RD_ADDR_OUT), 64'd10);
    end
    bus.EX_HOLD = 1'b0;
    set_instr(7'b0010011, 3'b100, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd4, 5'd20, 32'h400);
    step();
    check("hold_release_pc", 64'(bus.PC_IN_OUT), 64'h400);
    check("hold_release_rd", 64'(bus.RD_ADDR_OUT), 64'd20);

    // Load-use under EX_HOLD: no bubble until the hold drops
    set_instr(7'b0000011, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 5'd6, 32'h500);
    step();
    set_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 5'd1, 5'd7, 32'h504);
    bus.EX_HOLD = 1'b1;
    #1;
    check("hold_lu_stall", 64'(bus.STALL), 64'd1);
    step();
    check("hold_lu_pc", 64'(bus.PC_IN_OUT), 64'h500);
    check("hold_lu_memread", 64'(bus.MEM_READ_OUT), 64'd1);
`ifdef ID_EX_BUBBLE_COUNT_EN
    check("hold_lu_count", 64'(bus.BUBBLE_COUNT), 64'd1);
`endif
    bus.EX_HOLD = 1'b0;
    #1;
    check("hold_drop_stall", 64'(bus.STALL), 64'd1);
    step();
    check("hold_drop_bubble", 64'(ctrl_out), 64'd0);
`ifdef ID_EX_BUBBLE_COUNT_EN
    check("hold_drop_count", 64'(bus.BUBBLE_COUNT), 64'd2);
`endif
    step();
    check("hold_drop_issue", 64'(bus.PC_IN_OUT), 64'h504);

    // Reset in the middle of a stall
    set_instr(7'b0000011, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 5'd6, 32'h600);
    step();
    set_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 5'd1, 5'd7, 32'h604);
    #1;
    check("pre_rst_stall", 64'(bus.STALL), 64'd1);
    #1;
    RESET = 1'b1;
    #1;
    check("mid_rst_outputs", 64'(|all_out), 64'd0);
    check("mid_rst_stall", 64'(bus.STALL), 64'd0);
`ifdef ID_EX_BUBBLE_COUNT_EN
    check("mid_rst_count", 64'(bus.BUBBLE_COUNT), 64'd0);
`endif
    step();
    RESET = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
